// File: rtl/trig_arbiter.sv
`default_nettype none
// =====================================================================
// trig_arbiter : round-robin access to one shared 45-entry sin/cos LUT
// Optional macro TRIG_ARBITER_SIGN_EN adds quadrant signs.   Rev 1.0
// =====================================================================
module trig_arbiter #(
  parameter int N_REQ = 4,
  parameter int OUT_W = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [6*N_REQ-1:0]   req_angle,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [2:0]           resp_id,
  output logic [OUT_W-1:0]     resp_sin,
  output logic [OUT_W-1:0]     resp_cos,
  output logic                 busy
);

  localparam int              PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W:0]  C_N   = (PTR_W+1)'(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOOK = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [5:0]       angle_q, angle_d;
  logic [2:0]       id_q, id_d;
  logic [2:0]       resp_id_q, resp_id_d;
  logic [OUT_W-1:0] sin_q, sin_d;
  logic [OUT_W-1:0] cos_q, cos_d;

  logic             w_found;
  logic [PTR_W-1:0] w_gnt_idx;
  logic [PTR_W-1:0] w_next_ptr;
  logic [PTR_W:0]   w_cand;
  logic [PTR_W:0]   w_inc;
  logic [5:0]       w_gnt_angle;
  logic [N_REQ-1:0] w_gnt_onehot;
  logic             w_accept;
  logic [5:0]       w_norm;
  logic [4:0]       w_sin_mag;
  logic [4:0]       w_cos_mag;
  logic [OUT_W-1:0] w_sin_val;
  logic [OUT_W-1:0] w_cos_val;

  // First valid requester at or after rr_ptr, wrapping at N_REQ
  always_comb begin
    w_found     = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    w_gnt_angle = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (w_cand >= C_N) begin
        w_cand = w_cand - C_N;
      end
      if (!w_found && req_valid[w_cand[PTR_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[PTR_W-1:0];
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt_idx == PTR_W'(k)) begin
        w_gnt_angle = req_angle[6*k +: 6];
      end
    end
  end

  always_comb begin
    w_inc      = {1'b0, w_gnt_idx} + {{PTR_W{1'b0}}, 1'b1};
    w_next_ptr = (w_inc == C_N) ? '0 : w_inc[PTR_W-1:0];
  end

  assign w_gnt_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_gnt_idx;
  assign req_ready    = (state_q == ST_IDLE && w_found) ? w_gnt_onehot : '0;
  assign w_accept     = |(req_valid & req_ready);

  assign w_norm = (angle_q >= 6'd45) ? (angle_q - 6'd45) : angle_q;

  // Rounded |16*sin| and |16*cos| of (8 * index) degrees
  always_comb begin
    w_sin_mag = 5'd0;
    w_cos_mag = 5'd16;
    case (w_norm)
      6'd0:  begin w_sin_mag = 5'd0;  w_cos_mag = 5'd16; end
      6'd1:  begin w_sin_mag = 5'd2;  w_cos_mag = 5'd16; end
      6'd2:  begin w_sin_mag = 5'd4;  w_cos_mag = 5'd15; end
      6'd3:  begin w_sin_mag = 5'd7;  w_cos_mag = 5'd15; end
      6'd4:  begin w_sin_mag = 5'd8;  w_cos_mag = 5'd14; end
      6'd5:  begin w_sin_mag = 5'd10; w_cos_mag = 5'd12; end
      6'd6:  begin w_sin_mag = 5'd12; w_cos_mag = 5'd11; end
      6'd7:  begin w_sin_mag = 5'd13; w_cos_mag = 5'd9;  end
      6'd8:  begin w_sin_mag = 5'd14; w_cos_mag = 5'd7;  end
      6'd9:  begin w_sin_mag = 5'd15; w_cos_mag = 5'd5;  end
      6'd10: begin w_sin_mag = 5'd16; w_cos_mag = 5'd3;  end
      6'd11: begin w_sin_mag = 5'd16; w_cos_mag = 5'd1;  end
      6'd12: begin w_sin_mag = 5'd16; w_cos_mag = 5'd2;  end
      6'd13: begin w_sin_mag = 5'd16; w_cos_mag = 5'd4;  end
      6'd14: begin w_sin_mag = 5'd15; w_cos_mag = 5'd6;  end
      6'd15: begin w_sin_mag = 5'd14; w_cos_mag = 5'd8;  end
      6'd16: begin w_sin_mag = 5'd13; w_cos_mag = 5'd10; end
      6'd17: begin w_sin_mag = 5'd11; w_cos_mag = 5'd12; end
      6'd18: begin w_sin_mag = 5'd9;  w_cos_mag = 5'd13; end
      6'd19: begin w_sin_mag = 5'd8;  w_cos_mag = 5'd14; end
      6'd20: begin w_sin_mag = 5'd5;  w_cos_mag = 5'd15; end
      6'd21: begin w_sin_mag = 5'd3;  w_cos_mag = 5'd16; end
      6'd22: begin w_sin_mag = 5'd1;  w_cos_mag = 5'd16; end
      6'd23: begin w_sin_mag = 5'd1;  w_cos_mag = 5'd16; end
      6'd24: begin w_sin_mag = 5'd3;  w_cos_mag = 5'd16; end
      6'd25: begin w_sin_mag = 5'd5;  w_cos_mag = 5'd15; end
      6'd26: begin w_sin_mag = 5'd8;  w_cos_mag = 5'd14; end
      6'd27: begin w_sin_mag = 5'd9;  w_cos_mag = 5'd13; end
      6'd28: begin w_sin_mag = 5'd11; w_cos_mag = 5'd12; end
      6'd29: begin w_sin_mag = 5'd13; w_cos_mag = 5'd10; end
      6'd30: begin w_sin_mag = 5'd14; w_cos_mag = 5'd8;  end
      6'd31: begin w_sin_mag = 5'd15; w_cos_mag = 5'd6;  end
      6'd32: begin w_sin_mag = 5'd16; w_cos_mag = 5'd4;  end
      6'd33: begin w_sin_mag = 5'd16; w_cos_mag = 5'd2;  end
      6'd34: begin w_sin_mag = 5'd16; w_cos_mag = 5'd1;  end
      6'd35: begin w_sin_mag = 5'd16; w_cos_mag = 5'd3;  end
      6'd36: begin w_sin_mag = 5'd15; w_cos_mag = 5'd5;  end
      6'd37: begin w_sin_mag = 5'd14; w_cos_mag = 5'd7;  end
      6'd38: begin w_sin_mag = 5'd13; w_cos_mag = 5'd9;  end
      6'd39: begin w_sin_mag = 5'd12; w_cos_mag = 5'd11; end
      6'd40: begin w_sin_mag = 5'd10; w_cos_mag = 5'd12; end
      6'd41: begin w_sin_mag = 5'd8;  w_cos_mag = 5'd14; end
      6'd42: begin w_sin_mag = 5'd7;  w_cos_mag = 5'd15; end
      6'd43: begin w_sin_mag = 5'd4;  w_cos_mag = 5'd15; end
      6'd44: begin w_sin_mag = 5'd2;  w_cos_mag = 5'd16; end
      default: begin w_sin_mag = 5'd0; w_cos_mag = 5'd16; end
    endcase
  end

`ifdef TRIG_ARBITER_SIGN_EN
  logic w_sin_neg;
  logic w_cos_neg;

  // sin < 0 for 184..352 deg, cos < 0 for 96..264 deg
  always_comb begin
    w_sin_neg = (w_norm >= 6'd23);
    w_cos_neg = (w_norm >= 6'd12) && (w_norm <= 6'd33);
    w_sin_val = w_sin_neg ? (OUT_W'(0) - OUT_W'(w_sin_mag)) : OUT_W'(w_sin_mag);
    w_cos_val = w_cos_neg ? (OUT_W'(0) - OUT_W'(w_cos_mag)) : OUT_W'(w_cos_mag);
  end
`else
  always_comb begin
    w_sin_val = OUT_W'(w_sin_mag);
    w_cos_val = OUT_W'(w_cos_mag);
  end
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    angle_d   = angle_q;
    id_d      = id_q;
    resp_id_d = resp_id_q;
    sin_d     = sin_q;
    cos_d     = cos_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d  = ST_LOOK;
          angle_d  = w_gnt_angle;
          id_d     = 3'(w_gnt_idx);
          rr_ptr_d = w_next_ptr;
        end
      end
      ST_LOOK: begin
        state_d   = ST_RESP;
        resp_id_d = id_q;
        sin_d     = w_sin_val;
        cos_d     = w_cos_val;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      angle_q   <= '0;
      id_q      <= '0;
      resp_id_q <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      angle_q   <= angle_d;
      id_q      <= id_d;
      resp_id_q <= resp_id_d;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
    end
  end

  assign resp_valid = (state_q == ST_RESP) ? ({{(N_REQ-1){1'b0}}, 1'b1} << resp_id_q) : '0;
  assign resp_id    = resp_id_q;
  assign resp_sin   = sin_q;
  assign resp_cos   = cos_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_trig_arbiter.sv
`default_nettype none
// =====================================================================
// tb_trig_arbiter : randomized bench for trig_arbiter with a
// trigonometric reference model (TRIG_ARBITER_SIGN_EN aware). Rev 1.0
// =====================================================================
module tb_trig_arbiter;

  localparam int  N  = 4;
  localparam int  W  = 8;
  localparam real PI = 3.14159265358979;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [N-1:0] req_valid;
  logic [6*N-1:0] req_angle;
  logic [N-1:0] req_ready;
  logic [N-1:0] resp_valid;
  logic [2:0]   resp_id;
  logic [W-1:0] resp_sin;
  logic [W-1:0] resp_cos;
  logic         busy;

  trig_arbiter #(.N_REQ(N), .OUT_W(W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_angle  (req_angle),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_sin   (resp_sin),
    .resp_cos   (resp_cos),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: phase 0 idle, 1 lookup, 2 response
  int           m_phase, m_ptr, m_id, m_ang;
  logic [2:0]   e_id;
  logic [W-1:0] e_sin, e_cos;

  logic         d_rst;
  logic [N-1:0] d_valid;
  logic [6*N-1:0] d_angle;
  int           cyc;
  int           last_acc, acc_cyc;
  int           resp_cnt, last_resp_cyc;
  logic [N-1:0] last_resp_vec;
  int           glog_id[$];
  int           glog_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model_trig(input int ang, input bit want_cos);
    real deg, r, a;
    int  mag;
    deg = real'((ang % 45) * 8);
    r   = want_cos ? $cos(deg * PI / 180.0) : $sin(deg * PI / 180.0);
    r   = 16.0 * r;
    a   = (r < 0.0) ? -r : r;
    mag = $rtoi(a + 0.5);
`ifdef TRIG_ARBITER_SIGN_EN
    if (r < 0.0) mag = -mag;
`endif
    return W'(mag);
  endfunction

  function automatic int find_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_id = 0; m_ang = 0;
    e_id = '0; e_sin = '0; e_cos = '0;
  endtask

  // One clock: drive inputs at negedge, check after settle, advance the model
  task automatic step();
    int           g;
    logic [N-1:0] er;
    @(negedge Clk);
    Reset     = d_rst;
    req_valid = d_valid;
    req_angle = d_angle;
    #1;
    cyc++;
    g  = (m_phase == 0) ? find_grant(req_valid, m_ptr) : -1;
    er = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("resp_valid", 32'(resp_valid), (m_phase == 2) ? 32'(N'(1) << m_id) : 32'd0);
    chk("resp_id", 32'(resp_id), 32'(e_id));
    chk("resp_sin", 32'(resp_sin), 32'(e_sin));
    chk("resp_cos", 32'(resp_cos), 32'(e_cos));
    if (resp_valid != '0) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      last_resp_vec = resp_valid;
    end
    if (!Reset && |(req_valid & req_ready)) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          glog_id.push_back(i);
          glog_cyc.push_back(cyc);
        end
      end
    end
    last_acc = -1;
    if (Reset) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (g >= 0) begin
             m_id     = g;
             m_ang    = int'(req_angle[6*g +: 6]);
             m_ptr    = (g + 1) % N;
             m_phase  = 1;
             last_acc = g;
             acc_cyc  = cyc;
           end
        1: begin
             e_id    = 3'(m_id);
             e_sin   = model_trig(m_ang, 1'b0);
             e_cos   = model_trig(m_ang, 1'b1);
             m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic run_one(input int id, input int ang);
    int guard;
    d_rst = 1'b0;
    d_valid = N'(1) << id;
    d_angle[6*id +: 6] = 6'(ang);
    guard = 0;
    last_acc = -1;
    while (last_acc != id && guard < 20) begin
      step();
      guard++;
    end
    chk("accept_bound", 32'(last_acc == id), 32'd1);
    d_valid = '0;
    repeat (3) step();
  endtask

  task automatic gen_random();
    for (int i = 0; i < N; i++) begin
      if (d_valid[i] && last_acc == i) begin
        d_valid[i] = ($urandom_range(0, 1) == 1);
        d_angle[6*i +: 6] = 6'($urandom_range(0, 63));
      end else if (d_valid[i]) begin
        if ($urandom_range(0, 7) == 0) d_valid[i] = 1'b0;
        if ($urandom_range(0, 3) == 0) d_angle[6*i +: 6] = 6'($urandom_range(0, 63));
      end else if ($urandom_range(0, 2) == 0) begin
        d_valid[i] = 1'b1;
        d_angle[6*i +: 6] = 6'($urandom_range(0, 63));
      end
    end
    d_rst = ($urandom_range(0, 79) == 0);
  endtask

  initial begin
    logic [W-1:0] s47, c47;
    int guard;
    cyc = 0; last_acc = -1; acc_cyc = 0; resp_cnt = 0; last_resp_cyc = 0; last_resp_vec = '0;
    Reset = 1'b1; req_valid = '0; req_angle = '0;
    d_rst = 1'b0; d_valid = '0; d_angle = '0;
    repeat (2) @(negedge Clk);
    model_reset();

    // Idle after reset: everything quiet
    repeat (5) step();

    // Single request, requester 2, angle 0
    run_one(2, 0);
    chk("single_latency", 32'(last_resp_cyc - acc_cyc), 32'd2);
    chk("single_vec", 32'(last_resp_vec), 32'h4);
    chk("single_id", 32'(resp_id), 32'd2);
    chk("single_sin", 32'(resp_sin), 32'd0);
    chk("single_cos", 32'(resp_cos), 32'd16);
    chk("single_idle", 32'(busy), 32'd0);

    // Quadrant signs
    run_one(0, 30);
`ifdef TRIG_ARBITER_SIGN_EN
    chk("a30_sin", 32'(resp_sin), 32'hF2);
    chk("a30_cos", 32'(resp_cos), 32'hF8);
`else
    chk("a30_sin", 32'(resp_sin), 32'd14);
    chk("a30_cos", 32'(resp_cos), 32'd8);
`endif
    run_one(3, 40);
`ifdef TRIG_ARBITER_SIGN_EN
    chk("a40_sin", 32'(resp_sin), 32'hF6);
`else
    chk("a40_sin", 32'(resp_sin), 32'd10);
`endif
    chk("a40_cos", 32'(resp_cos), 32'd12);

    // Index wrap: 47 behaves as 2
    run_one(1, 47);
    s47 = resp_sin; c47 = resp_cos;
    chk("a47_sin", 32'(s47), 32'd4);
    chk("a47_cos", 32'(c47), 32'd15);
    run_one(1, 2);
    chk("a2_vs_a47_sin", 32'(resp_sin), 32'(s47));
    chk("a2_vs_a47_cos", 32'(resp_cos), 32'(c47));

    // Fairness: all requesters held from reset
    d_rst = 1'b1; d_valid = '1;
    for (int i = 0; i < N; i++) d_angle[6*i +: 6] = 6'($urandom_range(0, 63));
    step();
    d_rst = 1'b0;
    glog_id.delete(); glog_cyc.delete();
    repeat (14) step();
    chk("fair_count", 32'(glog_id.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < glog_id.size()) begin
        chk("fair_order", 32'(glog_id[i]), 32'(i % N));
        if (i > 0) chk("fair_gap", 32'(glog_cyc[i] - glog_cyc[i-1]), 32'd3);
      end
    end
    d_valid = '0;
    repeat (3) step();

    // Reset during LOOK discards the request; requester re-requests
    d_valid = 4'b0010;
    d_angle[6 +: 6] = 6'd30;
    guard = 0; last_acc = -1;
    while (last_acc != 1 && guard < 20) begin step(); guard++; end
    chk("rst_first_accept", 32'(last_acc == 1), 32'd1);
    resp_cnt = 0;
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    guard = 0; last_acc = -1;
    while (last_acc != 1 && guard < 20) begin step(); guard++; end
    chk("rst_reaccept", 32'(last_acc == 1), 32'd1);
    d_valid = '0;
    repeat (3) step();
    chk("rst_resp_count", 32'(resp_cnt), 32'd1);
    chk("rst_sin", 32'(resp_sin), 32'(model_trig(30, 1'b0)));
    chk("rst_cos", 32'(resp_cos), 32'(model_trig(30, 1'b1)));

    // Randomized traffic with occasional resets
    last_acc = -1;
    repeat (600) begin
      gen_random();
      step();
    end
    d_rst = 1'b0; d_valid = '0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
